// File: rtl/ps2_key_button_mapper.sv
// rtl/ps2_key_button_mapper.sv - runtime-programmable PS/2 key table driving held buttons,
// merged with joystick bits, with direction rotation and per-button autofire.
module ps2_key_button_mapper #(
    parameter int NUM_BTN = 16,
    parameter int AF_BITS = 20,
    parameter int IW      = $clog2(NUM_BTN)
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic [10:0]        ps2_key,
    input  logic               map_we,
    input  logic [IW-1:0]      map_idx,
    input  logic [8:0]         map_code,
    input  logic [NUM_BTN-1:0] joy_in,
    input  logic               rotate,
    input  logic [NUM_BTN-1:0] af_en,
    output logic [NUM_BTN-1:0] btn_held,
    output logic [NUM_BTN-1:0] btn_eff,
    output logic               key_event
);

    logic [8:0]         tbl_q [NUM_BTN];
    logic [8:0]         tbl_d [NUM_BTN];
    logic [NUM_BTN-1:0] btn_held_q, btn_held_d;
    logic [NUM_BTN-1:0] btn_eff_q, btn_eff_d;
    logic               key_event_q, key_event_d;
    logic               old_toggle_q;
    logic [AF_BITS-1:0] af_cnt_q, af_cnt_d;

    logic               evt;
    logic [NUM_BTN-1:0] hit;
    logic [NUM_BTN-1:0] merged;
    logic [NUM_BTN-1:0] rot;
    logic               af_on;

    always_comb begin
        evt        = (ps2_key[10] != old_toggle_q);
        hit        = '0;
        btn_held_d = btn_held_q;
        tbl_d      = tbl_q;
        // Matching uses the table as it stood before this cycle's write.
        for (int i = 0; i < NUM_BTN; i++) begin
            hit[i] = (tbl_q[i] != 9'h000) && (tbl_q[i] == ps2_key[8:0]);
            if (evt && hit[i]) begin
                btn_held_d[i] = ps2_key[9];
            end
            if (map_we && (map_idx == IW'(i))) begin
                tbl_d[i] = map_code;
            end
        end
        key_event_d = evt && (|hit);

        merged = btn_held_q | joy_in;
        rot    = merged;
        if (rotate) begin
            rot[3] = merged[1];
            rot[2] = merged[0];
            rot[1] = merged[2];
            rot[0] = merged[3];
        end

        // Counter parks at zero while idle so a fresh press starts in the fire phase.
        af_cnt_d = (|(rot & af_en)) ? af_cnt_q + AF_BITS'(1) : '0;
        af_on    = ~af_cnt_q[AF_BITS-1];
        for (int i = 0; i < NUM_BTN; i++) begin
            btn_eff_d[i] = rot[i] & (af_en[i] ? af_on : 1'b1);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                tbl_q[i] <= 9'h000;
            end
            btn_held_q   <= '0;
            btn_eff_q    <= '0;
            key_event_q  <= 1'b0;
            af_cnt_q     <= '0;
            old_toggle_q <= ps2_key[10];
        end else begin
            tbl_q        <= tbl_d;
            btn_held_q   <= btn_held_d;
            btn_eff_q    <= btn_eff_d;
            key_event_q  <= key_event_d;
            af_cnt_q     <= af_cnt_d;
            old_toggle_q <= ps2_key[10];
        end
    end

    assign btn_held  = btn_held_q;
    assign btn_eff   = btn_eff_q;
    assign key_event = key_event_q;

endmodule
